// File: rtl/dht11_data_proc.sv
// DHT11 post-processing: latches good humidity/temperature bytes, converts them to
// 3-digit BCD with a sequential double-dabble, and tracks consecutive failed reads.
module dht11_data_proc #(
  parameter int unsigned FAIL_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dht11_done,
  input  logic        dht11_valid,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  output logic [7:0]  hum_int,
  output logic [7:0]  temp_int,
  output logic [11:0] hum_bcd,
  output logic [11:0] temp_bcd,
  output logic        upd,
  output logic        data_ok,
  output logic        sensor_err,
  output logic [3:0]  fail_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic [2:0]  iter_q, iter_d;
  logic [19:0] hum_sr_q, hum_sr_d, temp_sr_q, temp_sr_d;
  logic [7:0]  hum_byte_q, hum_byte_d, temp_byte_q, temp_byte_d;
  logic [7:0]  hum_int_q, hum_int_d, temp_int_q, temp_int_d;
  logic [11:0] hum_bcd_q, hum_bcd_d, temp_bcd_q, temp_bcd_d;
  logic        upd_q, upd_d, data_ok_q, data_ok_d, sensor_err_q, sensor_err_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic        rise;

  // Fraction bytes are carried on the bus but never displayed.
  logic unused_frac;
  assign unused_frac = ^{humidity[7:0], temperature[7:0]};

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: add-3 correction then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  assign rise = dht11_done & ~done_q;

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    hum_sr_d     = hum_sr_q;
    temp_sr_d    = temp_sr_q;
    hum_byte_d   = hum_byte_q;
    temp_byte_d  = temp_byte_q;
    hum_int_d    = hum_int_q;
    temp_int_d   = temp_int_q;
    hum_bcd_d    = hum_bcd_q;
    temp_bcd_d   = temp_bcd_q;
    upd_d        = 1'b0;
    data_ok_d    = data_ok_q;
    fail_cnt_d   = fail_cnt_q;
    sensor_err_d = (fail_cnt_q >= 4'(FAIL_LIMIT));
    case (state_q)
      IDLE: begin
        if (rise && dht11_valid) begin
          hum_sr_d    = {12'h000, humidity[15:8]};
          temp_sr_d   = {12'h000, temperature[15:8]};
          hum_byte_d  = humidity[15:8];
          temp_byte_d = temperature[15:8];
          iter_d      = 3'd0;
          state_d     = CONV;
        end else if (rise) begin
          if (fail_cnt_q != 4'd15) fail_cnt_d = fail_cnt_q + 4'd1;
        end
      end
      CONV: begin
        hum_sr_d  = dabble_step(hum_sr_q);
        temp_sr_d = dabble_step(temp_sr_q);
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        hum_bcd_d  = hum_sr_q[19:8];
        temp_bcd_d = temp_sr_q[19:8];
        hum_int_d  = hum_byte_q;
        temp_int_d = temp_byte_q;
        fail_cnt_d = 4'd0;
        data_ok_d  = 1'b1;
        upd_d      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      iter_q       <= 3'd0;
      hum_sr_q     <= 20'd0;
      temp_sr_q    <= 20'd0;
      hum_byte_q   <= 8'd0;
      temp_byte_q  <= 8'd0;
      hum_int_q    <= 8'd0;
      temp_int_q   <= 8'd0;
      hum_bcd_q    <= 12'h000;
      temp_bcd_q   <= 12'h000;
      upd_q        <= 1'b0;
      data_ok_q    <= 1'b0;
      sensor_err_q <= 1'b0;
      fail_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      done_q       <= dht11_done;
      iter_q       <= iter_d;
      hum_sr_q     <= hum_sr_d;
      temp_sr_q    <= temp_sr_d;
      hum_byte_q   <= hum_byte_d;
      temp_byte_q  <= temp_byte_d;
      hum_int_q    <= hum_int_d;
      temp_int_q   <= temp_int_d;
      hum_bcd_q    <= hum_bcd_d;
      temp_bcd_q   <= temp_bcd_d;
      upd_q        <= upd_d;
      data_ok_q    <= data_ok_d;
      sensor_err_q <= sensor_err_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign hum_int    = hum_int_q;
  assign temp_int   = temp_int_q;
  assign hum_bcd    = hum_bcd_q;
  assign temp_bcd   = temp_bcd_q;
  assign upd        = upd_q;
  assign data_ok    = data_ok_q;
  assign sensor_err = sensor_err_q;
  assign fail_cnt   = fail_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dht11_data_proc.sv
// Directed bench for dht11_data_proc: conversion values, latency, failure counting,
// edge filtering during conversion and reset mid-conversion.
module tb_dht11_data_proc;

  logic        clk = 1'b0;
  logic        rst;
  logic        dht11_done, dht11_valid;
  logic [15:0] humidity, temperature;
  logic [7:0]  hum_int, temp_int;
  logic [11:0] hum_bcd, temp_bcd;
  logic        upd, data_ok, sensor_err;
  logic [3:0]  fail_cnt;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  logic upd_prev = 1'b0;

  dht11_data_proc #(.FAIL_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .dht11_done(dht11_done), .dht11_valid(dht11_valid),
    .humidity(humidity), .temperature(temperature),
    .hum_int(hum_int), .temp_int(temp_int), .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
    .upd(upd), .data_ok(data_ok), .sensor_err(sensor_err), .fail_cnt(fail_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // upd must be a single-cycle strobe
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      upd_cnt++;
      checks++;
      if (upd_prev === 1'b1) begin
        failures++;
        $display("FAIL upd_double got=consecutive exp=single");
      end
    end
    upd_prev = upd;
  end

  task automatic start_read(input logic [7:0] h, input logic [7:0] t, input logic v);
    @(negedge clk);
    humidity    = {h, 8'h5A};
    temperature = {t, 8'hA5};
    dht11_valid = v;
    dht11_done  = 1'b1;
  endtask

  // n = negedges from start_read until upd seen; 10 means upd in the cycle after E9
  task automatic wait_upd(output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (upd === 1'b1) break;
    end
  endtask

  task automatic end_read(input int hold);
    repeat (hold) @(negedge clk);
    dht11_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (hum_int !== 8'd0) begin failures++; $display("FAIL rst_hum_int got=%0d exp=0", hum_int); end
    checks++; if (temp_int !== 8'd0) begin failures++; $display("FAIL rst_temp_int got=%0d exp=0", temp_int); end
    checks++; if (hum_bcd !== 12'h000) begin failures++; $display("FAIL rst_hum_bcd got=%h exp=000", hum_bcd); end
    checks++; if (temp_bcd !== 12'h000) begin failures++; $display("FAIL rst_temp_bcd got=%h exp=000", temp_bcd); end
    checks++; if ({upd, data_ok, sensor_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {upd, data_ok, sensor_err}); end
    checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL rst_fail_cnt got=%0d exp=0", fail_cnt); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_valid_read;
    int n, base;
    base = upd_cnt;
    start_read(8'h37, 8'h19, 1'b1);
    wait_upd(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL valid_latency got=%0d exp=10", n); end
    checks++; if (hum_bcd !== 12'h055) begin failures++; $display("FAIL valid_hum_bcd got=%h exp=055", hum_bcd); end
    checks++; if (temp_bcd !== 12'h025) begin failures++; $display("FAIL valid_temp_bcd got=%h exp=025", temp_bcd); end
    checks++; if (hum_int !== 8'd55) begin failures++; $display("FAIL valid_hum_int got=%0d exp=55", hum_int); end
    checks++; if (temp_int !== 8'd25) begin failures++; $display("FAIL valid_temp_int got=%0d exp=25", temp_int); end
    checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL valid_data_ok got=%b exp=1", data_ok); end
    end_read(5000);
    checks++; if (upd_cnt - base !== 1) begin failures++; $display("FAIL valid_upd_count got=%0d exp=1", upd_cnt - base); end
    checks++; if (hum_bcd !== 12'h055 || temp_bcd !== 12'h025) begin failures++; $display("FAIL valid_stable got=%h/%h exp=055/025", hum_bcd, temp_bcd); end
  endtask

  task automatic test_boundary;
    logic [7:0]  h_tab [2] = '{8'hFF, 8'h63};
    logic [7:0]  t_tab [2] = '{8'h00, 8'h0A};
    logic [11:0] hb_tab[2] = '{12'h255, 12'h099};
    logic [11:0] tb_tab[2] = '{12'h000, 12'h010};
    int n;
    for (int i = 0; i < 2; i++) begin
      start_read(h_tab[i], t_tab[i], 1'b1);
      wait_upd(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL bound%0d_latency got=%0d exp=10", i, n); end
      checks++; if (hum_bcd !== hb_tab[i]) begin failures++; $display("FAIL bound%0d_hum_bcd got=%h exp=%h", i, hum_bcd, hb_tab[i]); end
      checks++; if (temp_bcd !== tb_tab[i]) begin failures++; $display("FAIL bound%0d_temp_bcd got=%h exp=%h", i, temp_bcd, tb_tab[i]); end
      checks++; if (hum_int !== h_tab[i] || temp_int !== t_tab[i]) begin failures++; $display("FAIL bound%0d_int got=%h/%h exp=%h/%h", i, hum_int, temp_int, h_tab[i], t_tab[i]); end
      end_read(20);
    end
  endtask

  task automatic test_fail_limit;
    int n, base;
    base = upd_cnt;
    for (int k = 1; k <= 3; k++) begin
      start_read(8'h11, 8'h22, 1'b0);
      @(negedge clk);
      checks++; if (fail_cnt !== 4'(k)) begin failures++; $display("FAIL fail%0d_cnt got=%0d exp=%0d", k, fail_cnt, k); end
      checks++; if (sensor_err !== 1'b0) begin failures++; $display("FAIL fail%0d_err_e0 got=%b exp=0", k, sensor_err); end
      @(negedge clk);
      checks++; if (sensor_err !== (k == 3)) begin failures++; $display("FAIL fail%0d_err_e1 got=%b exp=%b", k, sensor_err, k == 3); end
      end_read(10);
    end
    checks++; if (upd_cnt - base !== 0) begin failures++; $display("FAIL fail_no_upd got=%0d exp=0", upd_cnt - base); end
    checks++; if (hum_bcd !== 12'h099 || temp_bcd !== 12'h010 || hum_int !== 8'd99 || temp_int !== 8'd10) begin failures++; $display("FAIL fail_hold got=%h/%h exp=099/010", hum_bcd, temp_bcd); end
    start_read(8'h2A, 8'h05, 1'b1);
    wait_upd(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL recover_latency got=%0d exp=10", n); end
    checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL recover_cnt got=%0d exp=0", fail_cnt); end
    checks++; if (hum_bcd !== 12'h042 || temp_bcd !== 12'h005) begin failures++; $display("FAIL recover_bcd got=%h/%h exp=042/005", hum_bcd, temp_bcd); end
    @(negedge clk);
    checks++; if (sensor_err !== 1'b0) begin failures++; $display("FAIL recover_err got=%b exp=0", sensor_err); end
    end_read(10);
  endtask

  task automatic test_saturate;
    int base;
    base = upd_cnt;
    for (int k = 1; k <= 16; k++) begin
      start_read(8'h33, 8'h44, 1'b0);
      @(negedge clk);
      checks++; if (fail_cnt !== ((k < 15) ? 4'(k) : 4'd15)) begin failures++; $display("FAIL sat%0d_cnt got=%0d exp=%0d", k, fail_cnt, (k < 15) ? k : 15); end
      dht11_done = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++; if (sensor_err !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", sensor_err); end
    checks++; if (upd_cnt - base !== 0) begin failures++; $display("FAIL sat_no_upd got=%0d exp=0", upd_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int n, base;
    base = upd_cnt;
    start_read(8'h11, 8'h22, 1'b1);
    @(negedge clk);
    @(negedge clk);
    dht11_done  = 1'b0;
    humidity    = 16'h9900;
    temperature = 16'h8800;
    @(negedge clk);
    @(negedge clk);
    dht11_done = 1'b1;
    n = 4;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (upd === 1'b1) break;
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL b2b_latency got=%0d exp=10", n); end
    checks++; if (hum_bcd !== 12'h017 || temp_bcd !== 12'h034) begin failures++; $display("FAIL b2b_bcd got=%h/%h exp=017/034", hum_bcd, temp_bcd); end
    checks++; if (hum_int !== 8'd17 || temp_int !== 8'd34) begin failures++; $display("FAIL b2b_int got=%0d/%0d exp=17/34", hum_int, temp_int); end
    end_read(30);
    checks++; if (upd_cnt - base !== 1) begin failures++; $display("FAIL b2b_upd_count got=%0d exp=1", upd_cnt - base); end
  endtask

  task automatic test_reset_mid;
    int n, base;
    start_read(8'h4D, 8'h0C, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst        = 1'b1;
    dht11_done = 1'b0;
    base = upd_cnt;
    @(negedge clk);
    checks++; if (hum_bcd !== 12'h000 || temp_bcd !== 12'h000 || hum_int !== 8'd0 || temp_int !== 8'd0) begin failures++; $display("FAIL rmid_values got=%h/%h exp=000/000", hum_bcd, temp_bcd); end
    checks++; if ({upd, data_ok, sensor_err, fail_cnt} !== 7'd0) begin failures++; $display("FAIL rmid_flags got=%b exp=0000000", {upd, data_ok, sensor_err, fail_cnt}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (upd_cnt - base !== 0) begin failures++; $display("FAIL rmid_no_upd got=%0d exp=0", upd_cnt - base); end
    checks++; if (hum_bcd !== 12'h000 || data_ok !== 1'b0) begin failures++; $display("FAIL rmid_hold got=%h/%b exp=000/0", hum_bcd, data_ok); end
    start_read(8'h40, 8'h1E, 1'b1);
    wait_upd(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL rnext_latency got=%0d exp=10", n); end
    checks++; if (hum_bcd !== 12'h064 || temp_bcd !== 12'h030) begin failures++; $display("FAIL rnext_bcd got=%h/%h exp=064/030", hum_bcd, temp_bcd); end
    checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL rnext_data_ok got=%b exp=1", data_ok); end
    end_read(10);
  endtask

  initial begin
    rst         = 1'b1;
    dht11_done  = 1'b0;
    dht11_valid = 1'b0;
    humidity    = 16'h0000;
    temperature = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_valid_read;
    test_boundary;
    test_fail_limit;
    test_saturate;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
